// File: rtl/board_io_pkg.sv
// Shared constants and elaboration helpers for the board front-panel controller.
package board_io_pkg;

  localparam logic [1:0] LED_OFF     = 2'd0;
  localparam logic [1:0] LED_DIRECT  = 2'd1;
  localparam logic [1:0] LED_HEART   = 2'd2;
  localparam logic [1:0] LED_STRETCH = 2'd3;

  // Returns at least 1 so that a counter declared with it is never zero-width.
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >>> 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

  function automatic int ms_to_cycles(input int hz, input int ms);
    return (hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, polarity normalisation,
// stable-time debounce and single-cycle press/release events.
module key_debounce
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int              CNT_W    = clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic            IDLE_RAW = ACTIVE_LOW;

  logic             sync_p0;
  logic             sync_p1;
  logic             key_now;
  logic             differ;
  logic             settle;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: synchroniser preset to the idle pin level so reset release is quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= IDLE_RAW;
      sync_p1 <= IDLE_RAW;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign key_now = sync_p1 ^ ACTIVE_LOW;
  assign differ  = (key_now != key_level);
  assign settle  = differ && (cnt == CNT_LAST);

  // Debounce stage: level flips on the DB_CYCLES-th consecutive differing cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= settle && !key_level;
      key_release <= settle && key_level;
      if (!differ || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (settle) begin
        key_level <= ~key_level;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Board front-panel controller: debounced keys with press/release events,
// per-LED mode selection with pulse stretching, and the board heartbeat.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_KEYS         = 5,
  parameter int N_LEDS         = 5,
  parameter int CLK_HZ         = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int STRETCH_MS     = 100,
  parameter int HB_BITS        = 26,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_KEYS-1:0]     key_raw,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  input  logic [2*N_LEDS-1:0]   led_mode,
  input  logic [N_LEDS-1:0]     led_src,
  output logic [N_LEDS-1:0]     led,
  output logic                  heartbeat
);

  localparam int              DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int              ST_CYCLES = ms_to_cycles(CLK_HZ, STRETCH_MS);
  localparam int              ST_W      = clog2(ST_CYCLES + 1);
  localparam logic [ST_W-1:0] ST_LOAD   = ST_W'(ST_CYCLES);

  if (DB_CYCLES < 1) begin : g_bad_debounce
    $error("board_io_ctrl: debounce time rounds to zero cycles");
  end
  if (ST_CYCLES < 1) begin : g_bad_stretch
    $error("board_io_ctrl: stretch time rounds to zero cycles");
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_key_debounce (
      .clk         (sys_clk),
      .rst_n       (sys_rst_n),
      .key_raw     (key_raw[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k])
    );
  end

  logic [HB_BITS-1:0] hb_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + HB_BITS'(1);
    end
  end

  assign heartbeat = hb_cnt[HB_BITS-1];

  logic [N_LEDS-1:0] src_prev;
  logic [N_LEDS-1:0] stretch_active;
  logic [N_LEDS-1:0] led_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      src_prev <= '0;
    end else begin
      src_prev <= led_src;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    logic [ST_W-1:0] st_cnt;
    logic            led_sel;

    // Stretch timer runs in every mode so entering STRETCH shows the remaining time
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        st_cnt <= '0;
      end else if (led_src[i] && !src_prev[i]) begin
        st_cnt <= ST_LOAD;
      end else if (st_cnt != '0) begin
        st_cnt <= st_cnt - ST_W'(1);
      end
    end

    assign stretch_active[i] = (st_cnt != '0);

    always_comb begin
      led_sel = 1'b0;
      case (led_mode[2*i +: 2])
        LED_OFF:     led_sel = 1'b0;
        LED_DIRECT:  led_sel = led_src[i];
        LED_HEART:   led_sel = heartbeat;
        LED_STRETCH: led_sel = stretch_active[i];
        default:     led_sel = 1'b0;
      endcase
    end

    assign led_next[i] = led_sel;
  end

  // Output stage: single register keeps mode switches glitch-free
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with small timing parameters (DB=4, ST=10, HB=4).
module tb_board_io_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [4:0] key_raw;
  logic [4:0] key_level;
  logic [4:0] key_press;
  logic [4:0] key_release;
  logic [9:0] led_mode;
  logic [4:0] led_src;
  logic [4:0] led;
  logic       heartbeat;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  board_io_ctrl #(
    .N_KEYS         (5),
    .N_LEDS         (5),
    .CLK_HZ         (1000),
    .DEBOUNCE_MS    (4),
    .STRETCH_MS     (10),
    .HB_BITS        (4),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .led_mode    (led_mode),
    .led_src     (led_src),
    .led         (led),
    .heartbeat   (heartbeat)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges; inputs change and outputs are sampled at negedges.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      if (sys_rst_n) edges++;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_raw   = 5'b11111;
    led_mode  = '0;
    led_src   = '0;

    tick(3);
    check("rst_level", 32'(key_level), 32'h0);
    check("rst_press", 32'(key_press), 32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_hb", 32'(heartbeat), 32'h0);

    sys_rst_n = 1'b1;
    edges     = 0;

    // Idle keys and heartbeat period 16
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_level", 32'(key_level), 32'h0);
      check("idle_press", 32'(key_press), 32'h0);
      check("hb", 32'(heartbeat), 32'((edges >> 3) & 1));
    end

    // HEART mode on led[1]: registered copy of the previous heartbeat
    led_mode = 10'h008;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("heart_led", 32'(led), 32'((((edges - 1) >> 3) & 1) << 1));
    end

    // DIRECT mode on led[0] and a mode change to OFF
    led_mode = 10'h001;
    led_src  = 5'b00001;
    tick(1);
    check("direct_hi", 32'(led), 32'h01);
    led_src = 5'b00000;
    tick(1);
    check("direct_lo", 32'(led), 32'h00);
    led_src = 5'b00001;
    tick(1);
    check("direct_hi2", 32'(led), 32'h01);
    led_mode = 10'h000;
    tick(1);
    check("mode_off", 32'(led), 32'h00);
    led_src = 5'b00000;
    tick(15);

    // Key 0 press: level rises on the 6th edge with a single press pulse
    key_raw = 5'b11110;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("k0_level", 32'(key_level), (i >= 6) ? 32'h01 : 32'h00);
      check("k0_press", 32'(key_press), (i == 6) ? 32'h01 : 32'h00);
    end

    // Key 1 glitches of 3 cycles never reach the debounce time
    for (int r = 0; r < 5; r++) begin
      key_raw[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        check("glitch_level", 32'(key_level), 32'h01);
        check("glitch_press", 32'(key_press), 32'h00);
      end
      key_raw[1] = 1'b1;
      tick(1);
      check("glitch_gap", 32'(key_level), 32'h01);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("glitch_after", 32'(key_level), 32'h01);
      check("glitch_press2", 32'(key_press), 32'h00);
    end

    // Key 4 press, then keys 0 and 4 released together
    key_raw = 5'b01110;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("k4_press", 32'(key_press), (i == 6) ? 32'h10 : 32'h00);
    end
    check("k04_level", 32'(key_level), 32'h11);
    key_raw = 5'b11111;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("rel_pulse", 32'(key_release), (i == 6) ? 32'h11 : 32'h00);
      check("rel_level", 32'(key_level), (i >= 6) ? 32'h00 : 32'h11);
      check("rel_press", 32'(key_press), 32'h00);
    end

    // STRETCH on led[2]: single pulse gives 10 cycles
    led_mode = 10'h030;
    led_src  = 5'b00100;
    tick(1);
    led_src = 5'b00000;
    check("st1_start", 32'(led), 32'h00);
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      check("st1", 32'(led), (j <= 10) ? 32'h04 : 32'h00);
    end

    // Retrigger 5 cycles after the first pulse extends to 15 cycles
    led_src = 5'b00100;
    tick(1);
    led_src = 5'b00000;
    check("st2_start", 32'(led), 32'h00);
    for (int j = 1; j <= 17; j++) begin
      if (j == 5) led_src = 5'b00100;
      if (j == 6) led_src = 5'b00000;
      tick(1);
      check("st2", 32'(led), (j <= 15) ? 32'h04 : 32'h00);
    end

    // Switch led[3] into STRETCH mid-pulse: shows only the remaining time
    led_mode = 10'h000;
    led_src  = 5'b01000;
    tick(1);
    led_src = 5'b00000;
    for (int j = 1; j <= 12; j++) begin
      if (j == 5) led_mode = 10'h0C0;
      tick(1);
      check("st_mid", 32'(led), (j >= 5 && j <= 10) ? 32'h08 : 32'h00);
    end

    // Asynchronous reset mid-debounce and mid-stretch
    key_raw = 5'b10111;
    tick(6);
    check("k3_level", 32'(key_level), 32'h08);
    key_raw  = 5'b10101;
    tick(3);
    led_mode = 10'h030;
    led_src  = 5'b00100;
    tick(1);
    led_src = 5'b00000;
    tick(2);
    check("pre_rst_led", 32'(led), 32'h04);
    #2;
    sys_rst_n = 1'b0;
    key_raw   = 5'b11111;
    #1;
    check("arst_level", 32'(key_level), 32'h00);
    check("arst_led", 32'(led), 32'h00);
    check("arst_hb", 32'(heartbeat), 32'h0);
    check("arst_press", 32'(key_press), 32'h00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    edges     = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("post_press", 32'(key_press), 32'h00);
      check("post_release", 32'(key_release), 32'h00);
      check("post_level", 32'(key_level), 32'h00);
      check("post_led", 32'(led), 32'h00);
      check("post_hb", 32'(heartbeat), 32'((edges >> 3) & 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
